// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default sizing for the UART transmit scheduler.
package uart_pkg;

  // Scheduler phases: waiting for a request, byte on the wire, enforced idle gap
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } sched_state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int GAP_CLKS_DEF = 16;
  localparam int GAP_CNT_W    = 16;

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin picker. The search begins at i_ptr
// and wraps, so the first asserted request at or after the pointer wins.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
)
(
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [$clog2(N)-1:0] o_winner,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  // Walk from the farthest slot back to the pointer so the nearest request is the last write
  always_comb begin
    int idx;
    idx      = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (i_req[IW'(idx)]) begin
        o_winner = IW'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NUM_REQ byte requesters
// using round-robin arbitration and an enforced idle gap between bytes.
// Optional feature macro UART_SCHED_LOCK_EN: adds req_lock so the last granted
// requester can keep the transmitter for consecutive bytes.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int GAP_CLKS = GAP_CLKS_DEF
)
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
`ifdef UART_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CLKS);

  sched_state_t         r_state;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic [IW-1:0]        r_rr_ptr;
  logic [IW-1:0]        r_grant_id;
  logic [7:0]           r_tx_data;
  logic                 r_tx_start;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic                 r_busy;

  logic [IW-1:0]        w_rr_winner;
  logic                 w_rr_any;
  logic                 w_lock_hit;
  logic [IW-1:0]        w_winner;
  logic [IW-1:0]        w_next_ptr;
  logic [7:0]           w_sel_byte;

  uart_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_rr_winner),
    .o_any    (w_rr_any)
  );

`ifdef UART_SCHED_LOCK_EN
  assign w_lock_hit = req_lock[r_grant_id] & req_valid[r_grant_id];
`else
  assign w_lock_hit = 1'b0;
`endif

  assign w_winner   = w_lock_hit ? r_grant_id : w_rr_winner;
  assign w_next_ptr = (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + IW'(1);

  // Pick out the winning requester's byte from the flat data bus
  always_comb begin
    w_sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IW'(i)) w_sel_byte = req_data[8*i +: 8];
    end
  end

  // Scheduler FSM: launch one byte, wait for the stop bit, hold the gap, then rearbitrate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_req_ack  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_req_ack  <= '0;
      case (r_state)
        IDLE: begin
          if (w_rr_any && !tx_busy) begin
            r_grant_id <= w_winner;
            r_rr_ptr   <= w_next_ptr;
            r_tx_data  <= w_sel_byte;
            r_req_ack  <= NUM_REQ'(1) << w_winner;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (GAP_CLKS > 0) begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt <= GAP_CNT_W'(1)) begin
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ack  = r_req_ack;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios plus randomized traffic for the UART
// transmit scheduler, checked every cycle against a timestamp-based model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int NR  = 4;
  localparam int GAP = 16;
  localparam int IW  = $clog2(NR);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic            tx_busy = 1'b0;
  logic            tx_done = 1'b0;
  wire  [NR-1:0]   req_ack;
  wire  [7:0]      tx_data;
  wire             tx_start;
  wire  [IW-1:0]   grant_id;
  wire             busy;
`ifdef UART_SCHED_LOCK_EN
  logic [NR-1:0]   req_lock = '0;
  int              lockExp[4] = '{0, 0, 0, 1};
`endif

  int checks = 0;
  int errors = 0;

  // model state: a byte is either in flight or the scheduler is free from mReadyEdge on
  int            cyc = 0;
  int            mPtr = 0;
  int            mGid = 0;
  int            mReadyEdge = 0;
  bit            mInflight = 1'b0;
  logic          expStart = 1'b0;
  logic [NR-1:0] expAck = '0;
  logic [7:0]    expData = 8'h00;
  logic [IW-1:0] expGid = '0;
  logic          expBusy = 1'b0;

  // transmitter responder
  bit autoTx = 1'b0;
  bit noise = 1'b0;
  int fixedDelay = 0;
  int txCnt = 0;
  int stepNo = 0;
  int lastDone = -1;

  int expSeq[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(NR), .GAP_CLKS(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
`ifdef UART_SCHED_LOCK_EN
    .req_lock  (req_lock),
`endif
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Lock holder first (when enabled), otherwise first valid requester from the pointer on
  function automatic int pickWinner(input logic [NR-1:0] v);
`ifdef UART_SCHED_LOCK_EN
    if (req_lock[mGid] && v[mGid]) return mGid;
`endif
    for (int k = 0; k < NR; k++) begin
      if (v[(mPtr + k) % NR]) return (mPtr + k) % NR;
    end
    return 0;
  endfunction

  // Reference model: a launch may happen at any edge at or after mReadyEdge while free
  always @(posedge clk) begin
    int w;
    cyc++;
    if (!rst_n) begin
      mInflight = 1'b0; mPtr = 0; mGid = 0; mReadyEdge = 0;
      expStart = 1'b0; expAck = '0; expData = 8'h00; expGid = '0; expBusy = 1'b0;
    end else begin
      expStart = 1'b0;
      expAck   = '0;
      if (mInflight) begin
        if (tx_done) begin
          mInflight  = 1'b0;
          mReadyEdge = cyc + GAP + 1;
        end
      end else if (cyc >= mReadyEdge && req_valid != '0 && !tx_busy) begin
        w = pickWinner(req_valid);
        expStart  = 1'b1;
        expAck    = NR'(1) << w;
        expData   = req_data[8*w +: 8];
        expGid    = IW'(w);
        mGid      = w;
        mPtr      = (w + 1) % NR;
        mInflight = 1'b1;
      end
      expBusy = mInflight || (cyc + 1 < mReadyEdge);
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_tx_start", 32'(tx_start), 32'(0));
      checkOutput("rst_req_ack",  32'(req_ack),  32'(0));
      checkOutput("rst_tx_data",  32'(tx_data),  32'(0));
      checkOutput("rst_grant_id", 32'(grant_id), 32'(0));
      checkOutput("rst_busy",     32'(busy),     32'(0));
    end else begin
      checkOutput("tx_start", 32'(tx_start), 32'(expStart));
      checkOutput("req_ack",  32'(req_ack),  32'(expAck));
      checkOutput("tx_data",  32'(tx_data),  32'(expData));
      checkOutput("grant_id", 32'(grant_id), 32'(expGid));
      checkOutput("busy",     32'(busy),     32'(expBusy));
    end
  end

  // One clock: advance past the edge, then let the transmitter responder react
  task automatic step();
    @(posedge clk);
    #1;
    stepNo++;
    if (autoTx) begin
      tx_done = 1'b0;
      if (txCnt > 0) begin
        txCnt--;
        if (txCnt == 0) begin
          tx_done  = 1'b1;
          tx_busy  = 1'b0;
          lastDone = stepNo;
        end
      end else if (expStart) begin
        tx_busy = 1'b1;
        txCnt   = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(2, 12));
      end else if (noise) begin
        tx_busy = ($urandom_range(0, 5) == 0);
        if (!mInflight) tx_done = ($urandom_range(0, 9) == 0);
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    autoTx = 1'b0; noise = 1'b0; txCnt = 0; lastDone = -1;
    tx_busy = 1'b0; tx_done = 1'b0; req_valid = '0;
`ifdef UART_SCHED_LOCK_EN
    req_lock = '0;
`endif
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus();
    req_valid = NR'($urandom);
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'($urandom);
  endtask

  initial begin
    int n;
    int bound;
    int busyLow;
    bit found;

    // single request, first launch right after reset release
    doReset();
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'($urandom);
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    step();
    checkOutput("single_ack",   32'(req_ack),  32'h1);
    checkOutput("single_start", 32'(tx_start), 32'h1);
    checkOutput("single_data",  32'(tx_data),  32'hA5);
    checkOutput("single_gid",   32'(grant_id), 32'h0);
    req_valid = '0;
    step();
    checkOutput("single_ack_pulse",   32'(req_ack),  32'h0);
    checkOutput("single_start_pulse", 32'(tx_start), 32'h0);

    // fairness with all requesters active, plus gap spacing
    doReset();
    applyStimulus();
    req_valid = '1;
    autoTx = 1'b1; fixedDelay = 10; noise = 1'b0;
    n = 0; bound = 0; busyLow = 0;
    while (n < 5 && bound < 400) begin
      step();
      bound++;
      if (lastDone >= 0 && !busy) busyLow++;
      if (tx_start) begin
        checkOutput("fair_grant", 32'(grant_id), 32'(expSeq[n]));
        checkOutput("fair_ack",   32'(req_ack),  32'(1) << expSeq[n]);
        if (lastDone >= 0) begin
          checkOutput("gap_distance", 32'(stepNo - lastDone), 32'd18);
          checkOutput("gap_idle_cycles", 32'(busyLow), 32'd1);
        end
        n++;
        busyLow = 0;
      end
    end
    checkOutput("fair_count", 32'(n), 32'd5);

    // transmitter busy blocks launch
    doReset();
    tx_busy = 1'b1;
    req_valid = 4'b0010;
    repeat (6) begin
      step();
      checkOutput("txbusy_hold", 32'(tx_start), 32'h0);
    end
    tx_busy = 1'b0;
    step();
    checkOutput("txbusy_start", 32'(tx_start), 32'h1);
    checkOutput("txbusy_gid",   32'(grant_id), 32'h1);
    checkOutput("txbusy_ack",   32'(req_ack),  32'h2);

    // reset in the middle of a transfer
    doReset();
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    autoTx = 1'b1; fixedDelay = 10;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tx_start) found = 1'b1;
    end
    checkOutput("midrst_launch", 32'(found), 32'h1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_start", 32'(tx_start), 32'h0);
    checkOutput("midrst_ack",   32'(req_ack),  32'h0);
    checkOutput("midrst_data",  32'(tx_data),  32'h0);
    checkOutput("midrst_gid",   32'(grant_id), 32'h0);
    checkOutput("midrst_busy",  32'(busy),     32'h0);
    autoTx = 1'b0; txCnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
    req_valid = 4'b1000;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checkOutput("postrst_start", 32'(tx_start), 32'h1);
    checkOutput("postrst_ack",   32'(req_ack),  32'h8);
    checkOutput("postrst_gid",   32'(grant_id), 32'h3);

`ifdef UART_SCHED_LOCK_EN
    // lock keeps requester 0 until released
    doReset();
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    autoTx = 1'b1; fixedDelay = 3;
    n = 0; bound = 0;
    while (n < 4 && bound < 300) begin
      step();
      bound++;
      if (tx_start) begin
        checkOutput("lock_grant", 32'(grant_id), 32'(lockExp[n]));
        n++;
        if (n == 3) req_lock = '0;
      end
    end
    checkOutput("lock_count", 32'(n), 32'd4);
`endif

    // randomized traffic with transmitter noise and one asynchronous reset
    doReset();
    autoTx = 1'b1; fixedDelay = 0; noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
`ifdef UART_SCHED_LOCK_EN
      req_lock = NR'($urandom);
`endif
      if (i == 1500) begin
        rst_n = 1'b0;
        txCnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    autoTx = 1'b0;
    req_valid = '0;
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
